port_sched_wrr: RTL
===================

// Module: port_sched_wrr
// PURPOSE
//  Per-port read scheduler: picks which of QUEUE_NUM queues is read next.
//  Modes: strict priority, or weighted round robin (WRR) with per-queue
//  programmable weights.
//  Sits between the port's queue-state tracker (queue_empty) and the read
//  engine (prior_update / prior_next).
// PARAMETERS
//  QUEUE_NUM  8  number of queues per port; queue 0 = highest priority
//  WEIGHT_W   4  width of each WRR weight and credit counter
//  QIDX_W     $clog2(QUEUE_NUM)  queue index width (derived, do not override)
// PORTS
//  clk          in   1                    clock
//  rst_n        in   1                    async active-low reset
//  wrr_en       in   1                    0 = strict priority, 1 = WRR
//  wrr_weight   in   QUEUE_NUM*WEIGHT_W   packed weights, queue i at [i*WEIGHT_W +: WEIGHT_W]
//  queue_empty  in   QUEUE_NUM            1 = queue i empty
//  prior_update in   1                    pulse: grant on prior_next consumed
//  prior_next   out  QIDX_W               granted queue index (registered)
//  prior_valid  out  1                    prior_next is a legal grant
// BEHAVIOUR
//  - Reset: prior_next=0, prior_valid=0, all credits=0, round state RELOAD.
//  - Eligible(i) = ~queue_empty[i] & (wrr_en ? credit[i]!=0 : 1).
//  - Grant = lowest eligible index. It is registered: prior_next/prior_valid
//    update every clk from current state (1-cycle latency).
//  - prior_update with prior_valid=1 at edge t:
//    - WRR: credit[prior_next] decrements.
//    - Both modes: prior_valid=0 after edge t.
//    - Next grant visible after edge t+1.
//  - prior_update with prior_valid=0 is ignored.
//  - FSM, WRR only:
//    - RUN: normal granting.
//    - RUN->RELOAD when no queue is eligible and some ~queue_empty[i] has
//      wrr_weight[i]!=0.
//    - RELOAD (1 cycle, prior_valid=0): credit[i]<=wrr_weight[i] for all i,
//      then go to RUN.
//  - Weight 0 excludes a queue in WRR mode. If every non-empty queue has
//    weight 0: prior_valid=0, no reload (no livelock).
//  - Weight changes take effect at the next RELOAD only.
//  - wrr_en=0: state held in RELOAD, credits reloaded every cycle, so
//    enabling WRR starts a fresh round.
//  - queue_empty may change at any time; grant re-evaluated next edge.
//    Consumer must sample prior_next only while prior_valid=1.
//  - Credit decrement never underflows: a granted queue always has
//    credit>=1.
//  - prior_update coinciding with RELOAD: decrement happens first, the
//    reload then overwrites it.
// CONFIGURATION
//  PORT_SCHED_GRANT_CNT_EN defined:
//  - Adds input grant_cnt_clr (1) and output grant_cnt (QUEUE_NUM*16).
//  - Per-queue 16-bit saturating count of accepted prior_update; reset 0.
//  - grant_cnt_clr zeroes all counters and wins over a same-cycle increment.
//  Undefined: these ports and counters do not exist; behaviour is otherwise
//  identical.
// STRUCTURE
//  - Shared header port_sched_defs.vh: default QUEUE_NUM/WEIGHT_W, FSM state
//    encodings (RUN/RELOAD), clog2 helper.
//  - Sub-module prio_enc_lsb #(W): parametrised lowest-set-bit encoder
//    returning index + found flag. It replaces the fixed 8:3 encoder.
// TESTING
//  1. wrr_en=0, queue_empty=8'b1111_0101 -> prior_next=1, valid=1; after an
//     update -> 1 again (strict).
//  2. wrr_en=1, weights q0=2,q1=1, both non-empty, update every valid ->
//     grant sequence 0,0,1,(reload),0,0,1.
//  3. WRR, only q3 non-empty, weight q3=0 -> prior_valid stays 0 for 20
//     cycles, no RELOAD entered.
//  4. prior_update while prior_valid=0 -> credits unchanged, grant order
//     unaffected.
//  5. rst_n low mid-round (q0 credit 1 left) -> outputs 0 immediately;
//     after release: RELOAD, then full weights restored.
//  6. PORT_SCHED_GRANT_CNT_EN: 3 updates on q2 -> grant_cnt[q2]=3;
//     grant_cnt_clr with an update same cycle -> 0.

Source files
------------

// File: rtl/port_sched_wrr_pkg.sv
// Shared definitions for the per-port WRR read scheduler: default sizes,
// round-state encoding and the index-width helper.
package port_sched_wrr_pkg;

  localparam int unsigned DEF_QUEUE_NUM = 8;
  localparam int unsigned DEF_WEIGHT_W  = 4;
  localparam int unsigned GRANT_CNT_W   = 16;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_RELOAD = 1'b1
  } sched_state_e;

  // Never returns 0, so a one-queue port still has a 1-bit index.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/port_sched_wrr_prio_enc_lsb.sv
// Parametrised lowest-set-bit encoder: index of the lowest request bit
// plus a found flag.
module prio_enc_lsb
  import port_sched_wrr_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned IW = clog2(W)
) (
  input  logic [W-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (req[i] && !found) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/port_sched_wrr.sv
// Per-port read scheduler: strict priority or weighted round robin.
// Optional per-queue grant counters under `PORT_SCHED_GRANT_CNT_EN.
module port_sched_wrr
  import port_sched_wrr_pkg::*;
#(
  parameter int unsigned QUEUE_NUM = DEF_QUEUE_NUM,
  parameter int unsigned WEIGHT_W  = DEF_WEIGHT_W,
  parameter int unsigned QIDX_W    = clog2(QUEUE_NUM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wrr_en,
  input  logic [QUEUE_NUM*WEIGHT_W-1:0] wrr_weight,
  input  logic [QUEUE_NUM-1:0]          queue_empty,
  input  logic                          prior_update,
`ifdef PORT_SCHED_GRANT_CNT_EN
  input  logic                          grant_cnt_clr,
  output logic [QUEUE_NUM*GRANT_CNT_W-1:0] grant_cnt,
`endif
  output logic [QIDX_W-1:0]             prior_next,
  output logic                          prior_valid
);

  sched_state_e        state_q, state_d;
  logic [WEIGHT_W-1:0] credit_q [QUEUE_NUM];
  logic [WEIGHT_W-1:0] credit_d [QUEUE_NUM];
  logic [QIDX_W-1:0]   prior_next_q, prior_next_d;
  logic                prior_valid_q, prior_valid_d;
  logic [QUEUE_NUM-1:0] eligible, reloadable;
  logic [QIDX_W-1:0]   enc_idx;
  logic                enc_found;
  logic                upd_accept;

  prio_enc_lsb #(.W(QUEUE_NUM), .IW(QIDX_W)) u_enc (
    .req   (eligible),
    .idx   (enc_idx),
    .found (enc_found)
  );

  always_comb begin
    upd_accept = prior_update & prior_valid_q;
    for (int unsigned i = 0; i < QUEUE_NUM; i++) begin
      eligible[i]   = ~queue_empty[i] & (~wrr_en | (credit_q[i] != '0));
      reloadable[i] = ~queue_empty[i] & (wrr_weight[i*WEIGHT_W +: WEIGHT_W] != '0);
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    prior_next_d  = prior_next_q;
    prior_valid_d = 1'b0;

    if (wrr_en && upd_accept && (credit_q[prior_next_q] != '0))
      credit_d[prior_next_q] = credit_q[prior_next_q] - WEIGHT_W'(1);

    // Reload is applied after the decrement so it wins when both coincide.
    if (!wrr_en || (state_q == ST_RELOAD)) begin
      for (int unsigned i = 0; i < QUEUE_NUM; i++)
        credit_d[i] = wrr_weight[i*WEIGHT_W +: WEIGHT_W];
    end

    if (!wrr_en)
      state_d = ST_RELOAD;
    else if (state_q == ST_RELOAD)
      state_d = ST_RUN;
    else if (!enc_found && (|reloadable))
      state_d = ST_RELOAD;

    if (!upd_accept && enc_found && (!wrr_en || (state_q == ST_RUN))) begin
      prior_next_d  = enc_idx;
      prior_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RELOAD;
      prior_next_q  <= '0;
      prior_valid_q <= 1'b0;
      for (int unsigned i = 0; i < QUEUE_NUM; i++)
        credit_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      prior_next_q  <= prior_next_d;
      prior_valid_q <= prior_valid_d;
      credit_q      <= credit_d;
    end
  end

  assign prior_next  = prior_next_q;
  assign prior_valid = prior_valid_q;

`ifdef PORT_SCHED_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] gcnt_q [QUEUE_NUM];
  logic [GRANT_CNT_W-1:0] gcnt_d [QUEUE_NUM];

  always_comb begin
    gcnt_d = gcnt_q;
    if (grant_cnt_clr) begin
      for (int unsigned i = 0; i < QUEUE_NUM; i++)
        gcnt_d[i] = '0;
    end else if (upd_accept && (gcnt_q[prior_next_q] != '1)) begin
      gcnt_d[prior_next_q] = gcnt_q[prior_next_q] + GRANT_CNT_W'(1);
    end
    for (int unsigned i = 0; i < QUEUE_NUM; i++)
      grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W] = gcnt_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < QUEUE_NUM; i++)
        gcnt_q[i] <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end
`endif

endmodule
